// File: rtl/mem_wb_stage_if.sv
// MEM->WB stage bus: producer side (in_*), consumer side (out_*), forwarding tap and occupancy.
// The master modport is the environment (MEM stage plus register file); the slave modport is the stage.
interface mem_wb_stage_if #(
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned REG_ADDR_W = 5,
   parameter int unsigned WB_CTRL_W  = 2
);
   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_W-1:0]     in_read_data;
   logic [DATA_W-1:0]     in_alu_result;
   logic [REG_ADDR_W-1:0] in_write_dest;
   logic [WB_CTRL_W-1:0]  in_wb_ctrl;

   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_W-1:0]     out_read_data;
   logic [DATA_W-1:0]     out_alu_result;
   logic [REG_ADDR_W-1:0] out_write_dest;
   logic [WB_CTRL_W-1:0]  out_wb_ctrl;
   logic                  out_reg_write;
   logic                  out_mem_to_reg;
   logic [DATA_W-1:0]     out_wb_data;

   logic                  fwd_valid;
   logic [REG_ADDR_W-1:0] fwd_dest;
   logic [DATA_W-1:0]     fwd_data;
   logic [1:0]            occupancy;

   modport master (
      output in_valid, in_read_data, in_alu_result, in_write_dest, in_wb_ctrl, out_ready,
      input  in_ready, out_valid, out_read_data, out_alu_result, out_write_dest, out_wb_ctrl,
      input  out_reg_write, out_mem_to_reg, out_wb_data, fwd_valid, fwd_dest, fwd_data, occupancy
   );

   modport slave (
      input  in_valid, in_read_data, in_alu_result, in_write_dest, in_wb_ctrl, out_ready,
      output in_ready, out_valid, out_read_data, out_alu_result, out_write_dest, out_wb_ctrl,
      output out_reg_write, out_mem_to_reg, out_wb_data, fwd_valid, fwd_dest, fwd_data, occupancy
   );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM->WB pipeline stage: head/skid two-entry buffer with valid/ready handshake, flush,
// decoded WB controls, writeback mux and EX forwarding tap driven from the head entry.
module mem_wb_stage #(
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned REG_ADDR_W = 5,
   parameter int unsigned WB_CTRL_W  = 2,
   parameter bit          ZERO_REG   = 1'b1
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           flush,
   mem_wb_stage_if.slave  bus
);
   typedef struct packed {
      logic [DATA_W-1:0]     read_data;
      logic [DATA_W-1:0]     alu_result;
      logic [REG_ADDR_W-1:0] write_dest;
      logic [WB_CTRL_W-1:0]  wb_ctrl;
   } entry_t;

   entry_t in_entry;
   entry_t h_q, h_d, s_q, s_d;
   logic   h_valid_q, h_valid_d;
   logic   s_valid_q, s_valid_d;
   logic   ready_q;
   logic   accept;
   logic   pop;
   logic   dest_is_zero;

   assign in_entry = '{read_data:  bus.in_read_data,
                       alu_result: bus.in_alu_result,
                       write_dest: bus.in_write_dest,
                       wb_ctrl:    bus.in_wb_ctrl};

   assign accept = bus.in_valid & ready_q;
   assign pop    = h_valid_q & bus.out_ready;

   // Next-state for head/skid; flush wins over any same-cycle accept or pop.
   always_comb begin
      h_d       = h_q;
      s_d       = s_q;
      h_valid_d = h_valid_q;
      s_valid_d = s_valid_q;
      if (flush) begin
         h_valid_d = 1'b0;
         s_valid_d = 1'b0;
      end else if (!h_valid_q) begin
         if (accept) begin
            h_d       = in_entry;
            h_valid_d = 1'b1;
         end
      end else if (pop) begin
         if (s_valid_q) begin
            h_d       = s_q;
            s_valid_d = 1'b0;
         end else if (accept) begin
            h_d = in_entry;
         end else begin
            h_valid_d = 1'b0;
         end
      end else if (accept) begin
         s_d       = in_entry;
         s_valid_d = 1'b1;
      end
   end

   // ready_q mirrors !s_valid but stays low while in reset so all outputs read 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h_q       <= '0;
         s_q       <= '0;
         h_valid_q <= 1'b0;
         s_valid_q <= 1'b0;
         ready_q   <= 1'b0;
      end else begin
         h_q       <= h_d;
         s_q       <= s_d;
         h_valid_q <= h_valid_d;
         s_valid_q <= s_valid_d;
         ready_q   <= !s_valid_d;
      end
   end

   assign dest_is_zero = ZERO_REG && (h_q.write_dest == '0);

   assign bus.in_ready       = ready_q;
   assign bus.out_valid      = h_valid_q;
   assign bus.out_read_data  = h_q.read_data;
   assign bus.out_alu_result = h_q.alu_result;
   assign bus.out_write_dest = h_q.write_dest;
   assign bus.out_wb_ctrl    = h_q.wb_ctrl;
   assign bus.out_reg_write  = h_valid_q & h_q.wb_ctrl[0] & !dest_is_zero;
   assign bus.out_mem_to_reg = h_q.wb_ctrl[1];
   assign bus.out_wb_data    = h_q.wb_ctrl[1] ? h_q.read_data : h_q.alu_result;
   assign bus.fwd_valid      = bus.out_reg_write;
   assign bus.fwd_dest       = bus.out_write_dest;
   assign bus.fwd_data       = bus.out_wb_data;
   assign bus.occupancy      = 2'(h_valid_q) + 2'(s_valid_q);
endmodule
